// File: rtl/shift_feed_ctrl.sv
// Feeds nibbles from a small input FIFO into a 4-stage shift chain.
// It flags each complete word and stalls the chain until the consumer acknowledges the word.
module shift_feed_ctrl #(
  parameter int DATA_W       = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int WORD_NIBBLES = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic                              flush,
  output logic [DATA_W-1:0]                 shift_din,
  output logic                              shift_en,
  output logic                              word_valid,
  input  logic                              word_ack,
  output logic [$clog2(WORD_NIBBLES)-1:0]   fill_count,
  output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = $clog2(WORD_NIBBLES);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [FW-1:0] LAST_C  = FW'(WORD_NIBBLES - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t            state, state_nxt;
  logic [FW-1:0]     fill, fill_nxt;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wptr, rptr;
  logic [AW:0]       cnt;
  logic              empty, full, push, pop;

  assign empty      = (cnt == '0);
  assign full       = (cnt == DEPTH_C);
  assign in_ready   = !full && !reset;
  assign push       = in_valid && in_ready && !flush;
  assign shift_en   = !empty && ((state == FILL) || word_ack) && !flush;
  assign pop        = shift_en;
  assign shift_din  = empty ? '0 : mem[rptr];
  assign word_valid = (state == HOLD);
  assign fill_count = fill;
  assign fifo_count = cnt;

  // Input FIFO storage: data only, no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  // FIFO pointers and occupancy; the pointers wrap because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // Word-assembly state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FILL;
      fill  <= '0;
    end else begin
      state <= state_nxt;
      fill  <= fill_nxt;
    end
  end

  // An acknowledge in HOLD may shift the first nibble of the next word in the same cycle.
  always_comb begin
    state_nxt = state;
    fill_nxt  = fill;
    case (state)
      FILL: begin
        if (shift_en) begin
          if (fill == LAST_C) begin
            fill_nxt  = '0;
            state_nxt = HOLD;
          end else begin
            fill_nxt = fill + FW'(1);
          end
        end
      end
      HOLD: begin
        if (word_ack) begin
          state_nxt = FILL;
          if (shift_en) fill_nxt = FW'(1);
        end
      end
      default: state_nxt = FILL;
    endcase
    if (flush) begin
      state_nxt = FILL;
      fill_nxt  = '0;
    end
  end

endmodule
